// File: rtl/conv2d_edge_mul_arbiter.sv
// Round-robin arbiter sharing one external unsigned multiplier between NREQ requesters.
// Two register stages: operand register (drives the multiplier) and result register.
module conv2d_edge_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2,
    parameter int A_W  = 9,
    parameter int B_W  = 11,
    parameter int P_W  = 19
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*A_W-1:0] req_a,
    input  logic [NREQ*B_W-1:0] req_b,
    output logic [A_W-1:0]      mul_din0,
    output logic [B_W-1:0]      mul_din1,
    input  logic [P_W-1:0]      mul_dout,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [P_W-1:0]      res_data,
    output logic [ID_W-1:0]     res_id,
    output logic                busy
);

    logic            op_valid_q, op_valid_d;
    logic [A_W-1:0]  op_a_q, op_a_d;
    logic [B_W-1:0]  op_b_q, op_b_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    logic            res_valid_q, res_valid_d;
    logic [P_W-1:0]  res_data_q, res_data_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            s1_en, s2_en;
    logic            win_any, accept;
    logic [ID_W-1:0] win_id;
    int              idx;

    assign s2_en  = !res_valid_q || res_ready;
    assign s1_en  = !op_valid_q || s2_en;
    assign accept = win_any && s1_en && !ap_rst;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_any && req_valid[idx]) begin
                win_any = 1'b1;
                win_id  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_id] = 1'b1;
    end

    always_comb begin
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rr_ptr_d    = rr_ptr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        if (s1_en) begin
            op_valid_d = win_any;
            if (win_any) begin
                op_a_d   = req_a[win_id*A_W +: A_W];
                op_b_d   = req_b[win_id*B_W +: B_W];
                op_id_d  = win_id;
                rr_ptr_d = (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 1'b1;
            end
        end
        if (s2_en) begin
            res_valid_d = op_valid_q;
            if (op_valid_q) begin
                res_data_d = mul_dout;
                res_id_d   = op_id_q;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign mul_din0  = op_a_q;
    assign mul_din1  = op_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = op_valid_q || res_valid_q;

endmodule

// File: tb/tb_conv2d_edge_mul_arbiter.sv
// Bench for conv2d_edge_mul_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model (in-flight queue, two-deep capacity, round-robin pointer).
module tb_conv2d_edge_mul_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int A_W  = 9;
    localparam int B_W  = 11;
    localparam int P_W  = 19;

    logic                ap_clk = 1'b0;
    logic                ap_rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*A_W-1:0] req_a = '0;
    logic [NREQ*B_W-1:0] req_b = '0;
    logic [A_W-1:0]      mul_din0;
    logic [B_W-1:0]      mul_din1;
    logic [P_W-1:0]      mul_dout;
    logic                res_valid;
    logic                res_ready = 1'b1;
    logic [P_W-1:0]      res_data;
    logic [ID_W-1:0]     res_id;
    logic                busy;
    logic [A_W+B_W-1:0]  full_prod;

    conv2d_edge_mul_arbiter #(
        .NREQ(NREQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    // External combinational multiplier, truncated to P_W bits.
    assign full_prod = (A_W+B_W)'(mul_din0) * (A_W+B_W)'(mul_din1);
    assign mul_dout  = full_prod[P_W-1:0];

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int id;
        int a;
        int b;
        int prod;
        bit fresh;
    } item_t;

    item_t q[$];
    int    ptr = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*A_W +: A_W] = A_W'(a);
        req_b[i*B_W +: B_W] = B_W'(b);
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        int              w;
        logic [NREQ-1:0] exp_rdy;
        bit              exp_rv, allowed, pop, push;
        item_t           it;
        @(negedge ap_clk);
        exp_rv  = (q.size() > 0) && !q[0].fresh;
        allowed = !ap_rst && ((q.size() < 2) || res_ready);
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (w < 0 && req_valid[j]) w = j;
        end
        exp_rdy = '0;
        if (allowed && w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (exp_rv) begin
            chk("res_data", 32'(res_data), 32'(q[0].prod));
            chk("res_id", 32'(res_id), 32'(q[0].id));
            if (q[0].a == 511 && q[0].b == 2047) chk("trunc_max", 32'(res_data), 32'd521729);
            if (q[0].a == 3 && q[0].b == 5) chk("prod_3x5", 32'(res_data), 32'd15);
        end
        pop  = exp_rv && res_ready && !ap_rst;
        push = allowed && (w >= 0);
        it.id = 0; it.a = 0; it.b = 0; it.prod = 0; it.fresh = 1'b1;
        if (push) begin
            it.id   = w;
            it.a    = int'(req_a[w*A_W +: A_W]);
            it.b    = int'(req_b[w*B_W +: B_W]);
            it.prod = (it.a * it.b) % (1 << P_W);
        end
        @(posedge ap_clk);
        if (ap_rst) begin
            q.delete();
            ptr = 0;
        end else begin
            if (pop) q.delete(0);
            foreach (q[i]) q[i].fresh = 1'b0;
            if (push) begin
                q.push_back(it);
                ptr = (w + 1) % NREQ;
            end
        end
        #1;
    endtask

    initial begin
        int dens;
        int rdyp;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_din0", 32'(mul_din0), 32'd0);
        chk("rst_din1", 32'(mul_din1), 32'd0);
        step();

        // single request from requester 2
        ap_rst = 1'b0;
        set_req(2, 3, 5);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (3) step();

        // truncation corner
        set_req(0, 511, 2047);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (3) step();

        // all requesters continuously valid
        for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 100 + i);
        req_valid = '1;
        repeat (12) step();
        req_valid = '0;
        repeat (3) step();

        // backpressure with one continuous requester
        set_req(1, 77, 1234);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        repeat (5) step();
        res_ready = 1'b1;
        repeat (4) step();
        req_valid = '0;
        repeat (3) step();

        // sparse requesters 1 and 3 from a reset pointer
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        set_req(1, 21, 33);
        set_req(3, 45, 67);
        req_valid = 4'b1010;
        repeat (8) step();

        // reset with both stages full
        req_valid = '1;
        res_ready = 1'b0;
        repeat (3) step();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        res_ready = 1'b1;
        req_valid = 4'b1100;
        repeat (4) step();
        req_valid = '0;
        repeat (3) step();

        // random traffic with varying density, backpressure and occasional reset
        for (int n = 0; n < 2000; n++) begin
            if (n % 250 == 0) begin
                dens = int'($urandom_range(10, 100));
                rdyp = int'($urandom_range(20, 100));
            end
            for (int i = 0; i < NREQ; i++) begin
                set_req(i,
                        ($urandom_range(0, 3) == 0) ? 511 : int'($urandom_range(0, 511)),
                        ($urandom_range(0, 3) == 0) ? 2047 : int'($urandom_range(0, 2047)));
                req_valid[i] = (int'($urandom_range(0, 99)) < dens);
            end
            res_ready = (int'($urandom_range(0, 99)) < rdyp);
            ap_rst    = ($urandom_range(0, 199) == 0);
            step();
        end
        ap_rst    = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
